// File: rtl/gpr_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority over a
// FIFO-buffered multi-cycle producer (B), with forwarding over pending writes.
module gpr_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    a_valid,
    input  logic [4:0]              a_addr,
    input  logic [31:0]             a_data,
    input  logic [31:0]             a_pc,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [4:0]              b_addr,
    input  logic [31:0]             b_data,
    input  logic [31:0]             b_pc,
    output logic                    we,
    output logic [4:0]              a3,
    output logic [31:0]             wd,
    output logic [31:0]             wpc,
    input  logic [4:0]              q_addr,
    output logic                    q_hit,
    output logic [31:0]             q_data,
    output logic [$clog2(DEPTH):0]  pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [4:0]       ent_addr_q [DEPTH];
    logic [4:0]       ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [31:0]      ent_pc_q   [DEPTH];
    logic [31:0]      ent_pc_d   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    logic          we_q,  we_d;
    logic [4:0]    a3_q,  a3_d;
    logic [31:0]   wd_q,  wd_d;
    logic [31:0]   wpc_q, wpc_d;

    logic          a_req;
    logic          full;
    logic          push_xfer;
    logic          push_keep;
    logic          pop;
    logic [AW-1:0] fwd_idx;

    assign a_req     = a_valid && (a_addr != 5'd0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign b_ready   = !full;
    assign push_xfer = b_valid && b_ready;
    // A same-cycle A write to the same register is younger, so the B result is dead on arrival
    assign push_keep = push_xfer && (b_addr != 5'd0) && !(a_req && (a_addr == b_addr));
    assign pop       = !a_req && (cnt_q != '0);

    always_comb begin
        ent_vld_d  = ent_vld_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_pc_d   = ent_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (a_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_addr_q[i] == a_addr) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end

        if (push_keep) begin
            ent_vld_d[tail_q]  = 1'b1;
            ent_addr_d[tail_q] = b_addr;
            ent_data_d[tail_q] = b_data;
            ent_pc_d[tail_q]   = b_pc;
            tail_d             = tail_q + AW'(1);
        end

        if (pop) begin
            ent_vld_d[head_q] = 1'b0;
            head_d            = head_q + AW'(1);
        end

        case ({push_keep, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        we_d  = 1'b0;
        a3_d  = a3_q;
        wd_d  = wd_q;
        wpc_d = wpc_q;
        if (a_req) begin
            we_d  = 1'b1;
            a3_d  = a_addr;
            wd_d  = a_data;
            wpc_d = a_pc;
        end else if (pop && ent_vld_q[head_q]) begin
            we_d  = 1'b1;
            a3_d  = ent_addr_q[head_q];
            wd_d  = ent_data_q[head_q];
            wpc_d = ent_pc_q[head_q];
        end
    end

    // Walk head to tail so the youngest matching entry is the last one kept;
    // freed and squashed slots always have their valid bit clear.
    always_comb begin
        q_hit   = 1'b0;
        q_data  = 32'd0;
        fwd_idx = head_q;
        if (q_addr != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + AW'(i);
                if (ent_vld_q[fwd_idx] && (ent_addr_q[fwd_idx] == q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = ent_data_q[fwd_idx];
                end
            end
            if (!q_hit && we_q && (a3_q == q_addr)) begin
                q_hit  = 1'b1;
                q_data = wd_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ent_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= 5'd0;
                ent_data_q[i] <= 32'd0;
                ent_pc_q[i]   <= 32'd0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            a3_q   <= 5'd0;
            wd_q   <= 32'd0;
            wpc_q  <= 32'd0;
        end else begin
            ent_vld_q <= ent_vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= ent_addr_d[i];
                ent_data_q[i] <= ent_data_d[i];
                ent_pc_q[i]   <= ent_pc_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd_q   <= wd_d;
            wpc_q  <= wpc_d;
        end
    end

    assign we       = we_q;
    assign a3       = a3_q;
    assign wd       = wd_q;
    assign wpc      = wpc_q;
    assign pend_cnt = cnt_q;

endmodule
